// File: rtl/regfile_2r2w.sv
// Dual-write, dual-read register file with registered read data, optional
// same-edge write bypass, optional hardwired zero entry and a sequential clear sweep.
module regfile_2r2w #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int ADDRESSWIDTH = 5,
    parameter bit BYPASS       = 1'b1,
    parameter bit ZERO_REG     = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    weA,
    input  logic [ADDRESSWIDTH-1:0] destA,
    input  logic [WIDTH-1:0]        dataA,
    input  logic                    weB,
    input  logic [ADDRESSWIDTH-1:0] destB,
    input  logic [WIDTH-1:0]        dataB,
    input  logic                    reA,
    input  logic [ADDRESSWIDTH-1:0] srcA,
    output logic [WIDTH-1:0]        doutA,
    input  logic                    reB,
    input  logic [ADDRESSWIDTH-1:0] srcB,
    output logic [WIDTH-1:0]        doutB,
    input  logic                    clear,
    output logic                    busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDRESSWIDTH still compares correctly.
    localparam logic [ADDRESSWIDTH:0]   DEPTH_W  = (ADDRESSWIDTH + 1)'(DEPTH);
    localparam logic [ADDRESSWIDTH-1:0] LAST_IDX = ADDRESSWIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]        rf_r [DEPTH];
    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDRESSWIDTH-1:0] idx_r;
    logic [ADDRESSWIDTH-1:0] idx_next_s;
    logic                    sweep_we_s;
    logic                    wr_a_ok_s;
    logic                    wr_b_ok_s;
    logic [WIDTH-1:0]        rd_a_s;
    logic [WIDTH-1:0]        rd_b_s;

    function automatic logic addr_ok(input logic [ADDRESSWIDTH-1:0] addr);
        logic ok;
        ok = ({1'b0, addr} < DEPTH_W);
        if (ZERO_REG && (addr == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Accepted write data overrides the array word; port B has priority.
    function automatic logic [WIDTH-1:0] forward(
        input logic [ADDRESSWIDTH-1:0] src,
        input logic [WIDTH-1:0]        arr_word,
        input logic                    a_ok,
        input logic [ADDRESSWIDTH-1:0] a_dest,
        input logic [WIDTH-1:0]        a_data,
        input logic                    b_ok,
        input logic [ADDRESSWIDTH-1:0] b_dest,
        input logic [WIDTH-1:0]        b_data
    );
        logic [WIDTH-1:0] word;
        word = arr_word;
        if (BYPASS && b_ok && (b_dest == src)) begin
            word = b_data;
        end else if (BYPASS && a_ok && (a_dest == src)) begin
            word = a_data;
        end else begin
            word = arr_word;
        end
        return word;
    endfunction

    assign wr_a_ok_s = weA && (state_r == IDLE) && addr_ok(destA);
    assign wr_b_ok_s = weB && (state_r == IDLE) && addr_ok(destB);

    // Clear engine next-state and sweep index.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        sweep_we_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear) begin
                    state_next_s = SWEEP;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                    idx_next_s   = idx_r;
                end
            end
            SWEEP: begin
                sweep_we_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_next_s = IDLE;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = SWEEP;
                    idx_next_s   = idx_r + ADDRESSWIDTH'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // Read data selection: out-of-range and zero-register reads yield zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        if (addr_ok(srcA)) begin
            rd_a_s = forward(srcA, rf_r[srcA], wr_a_ok_s, destA, dataA, wr_b_ok_s, destB, dataB);
        end else begin
            rd_a_s = '0;
        end
        if (addr_ok(srcB)) begin
            rd_b_s = forward(srcB, rf_r[srcB], wr_a_ok_s, destA, dataA, wr_b_ok_s, destB, dataB);
        end else begin
            rd_b_s = '0;
        end
    end

    // Array, read registers and clear engine state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
            busy    <= 1'b0;
            doutA   <= '0;
            doutB   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rf_r[k] <= '0;
            end
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            busy    <= (state_next_s == SWEEP);
            if (reA) begin
                doutA <= rd_a_s;
            end
            if (reB) begin
                doutB <= rd_b_s;
            end
            if (sweep_we_s) begin
                rf_r[idx_r] <= '0;
            end else begin
                if (wr_a_ok_s) begin
                    rf_r[destA] <= dataA;
                end
                // Issued after port A so a same-address collision resolves to B.
                if (wr_b_ok_s) begin
                    rf_r[destB] <= dataB;
                end
            end
        end
    end

endmodule

// File: doc/regfile_2r2w.md
# regfile_2r2w

Parametrised dual-write, dual-read register file with registered read outputs, optional write-to-read bypass, optional hardwired zero register, and a sequential clear engine. It is the next-generation storage block for the datapath and replaces single-port register storage wherever two operands are read and two results are retired per cycle.

## Interface
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries (2 ≤ DEPTH ≤ 2^ADDRESSWIDTH)
- ADDRESSWIDTH, 5, address width of all ports
- BYPASS, 1, 1: same-cycle write data forwarded to reads; 0: reads return array contents only
- ZERO_REG, 0, 1: entry 0 reads as 0 and ignores writes
- Reset is `reset`, synchronous, active-low; the clock is `clock`.
- clock  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- weA  input  1  write enable, port A
- destA  input  ADDRESSWIDTH  write address, port A
- dataA  input  WIDTH  write data, port A
- weB  input  1  write enable, port B
- destB  input  ADDRESSWIDTH  write address, port B
- dataB  input  WIDTH  write data, port B
- reA  input  1  read enable, port A
- srcA  input  ADDRESSWIDTH  read address, port A
- doutA  output  WIDTH  registered read data, port A
- reB  input  1  read enable, port B
- srcB  input  ADDRESSWIDTH  read address, port B
- doutB  output  WIDTH  registered read data, port B
- clear  input  1  request a sweep that zeroes every entry
- busy  output  1  high while the clear sweep runs

## Operation
- Writes: on each edge with the engine IDLE, weA writes dataA to rf[destA] and weB writes dataB to rf[destB]. If destA==destB with both enabled, port B wins.
- Ignored writes: writes to an address ≥ DEPTH are dropped. With ZERO_REG=1, writes to address 0 are dropped.
- Reads: on each edge with reX=1, doutX loads rf[srcX]. With reX=0, doutX holds its value.
  - Address ≥ DEPTH loads 0.
  - ZERO_REG=1 and srcX==0 loads 0.
- Bypass (BYPASS=1, IDLE only): if a write that is accepted on the same edge targets srcX, doutX loads that write's data. Port B data takes priority over port A. Dropped writes are never bypassed.
- Clear engine, 2 states:
  - IDLE: clear=1 → SWEEP, idx←0.
  - SWEEP: each edge rf[idx]←0 and idx←idx+1. At idx==DEPTH-1, go to IDLE.
  - busy = (state==SWEEP).
- During SWEEP:
  - All port writes are dropped, with no bypass.
  - Reads proceed and return current array contents, so entries not yet cleared show old values.
  - clear is ignored.

## Timing
- Read latency 1 cycle: srcX sampled at edge N, doutX valid after edge N.
- Write at edge N is visible through the array to a read sampled at edge N+1. With BYPASS=1 it is also visible to a read sampled at edge N. With BYPASS=0, a read at edge N returns the old value.
- Clear sampled at edge N: busy high after edges N..N+DEPTH-1, i.e. exactly DEPTH cycles. rf[k] is zero after edge N+1+k. busy low after edge N+DEPTH. A new clear is accepted on the edge where busy is already low.
- Reset (reset=0 at an edge), highest priority:
  - all rf←0, doutA=doutB=0, busy=0, state IDLE, idx←0.
  - Reset mid-sweep aborts the sweep.
  - Writes, reads and clear sampled on a reset edge are ignored.
- idx is ADDRESSWIDTH bits wide and never exceeds DEPTH-1.

## Test plan
- Reset then dual write: reset low one edge; weA dest=3 data=0x11, weB dest=7 data=0x22; next cycle read srcA=3, srcB=7 → doutA=0x11, doutB=0x22. All outputs 0 immediately after reset.
- Write collision and bypass: BYPASS=1, same edge weA dest=5 data=0xAAAA, weB dest=5 data=0xBBBB, reA src=5 → doutA=0xBBBB on that edge; later read of 5 → 0xBBBB. Repeat with BYPASS=0: same-edge read returns the previous value (0).
- Read enable hold and zero register: ZERO_REG=1, write 0xFF to address 0, read 0 → 0. Load doutB=0x22, drop reB, change srcB → doutB stays 0x22.
- Clear sweep: fill all entries with their index+1, pulse clear → busy high exactly DEPTH cycles. weA dest=9 data=0x99 during busy is dropped. Read 31 at sweep cycle 2 → 32 (old value). After busy falls all reads → 0.
- Reset mid-sweep and out-of-range: DEPTH=20, assert reset at sweep cycle 4 → busy=0, all entries 0 on the next read. Write to address 25 is dropped; read of 25 → 0.
